// File: rtl/pixel_rect_writer.sv
// rtl/pixel_rect_writer.sv - raster-order single pixel / rectangle fill writer towards a display driver
module pixel_rect_writer #(
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 9,
  parameter int DATA_WIDTH = 16,
  parameter int X_MAX      = 239,
  parameter int Y_MAX      = 319
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  abort,
  input  logic [X_WIDTH-1:0]    xStart,
  input  logic [X_WIDTH-1:0]    xEnd,
  input  logic [Y_WIDTH-1:0]    yStart,
  input  logic [Y_WIDTH-1:0]    yEnd,
  input  logic [DATA_WIDTH-1:0] colour,
  input  logic                  pixelReady,
  output logic                  pixelWrite,
  output logic [X_WIDTH-1:0]    pixelXAddr,
  output logic [Y_WIDTH-1:0]    pixelYAddr,
  output logic [DATA_WIDTH-1:0] pixelData,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [X_WIDTH-1:0] xLimit = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0] yLimit = Y_WIDTH'(Y_MAX);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} stateT;

  stateT              state;
  logic [X_WIDTH-1:0] xFirst;
  logic [X_WIDTH-1:0] xLast;
  logic [Y_WIDTH-1:0] yLast;

  // Effective end corner: a single-pixel request ends where it starts
  logic [X_WIDTH-1:0] xLastReq;
  logic [Y_WIDTH-1:0] yLastReq;
  logic               reqValid;

  // Validate the request presented on the start cycle
  always_comb begin
    xLastReq = mode ? xEnd : xStart;
    yLastReq = mode ? yEnd : yStart;
    reqValid = 1'b1;
    if (xStart > xLimit || yStart > yLimit) reqValid = 1'b0;
    if (mode && (xEnd > xLimit || yEnd > yLimit || xEnd < xStart || yEnd < yStart)) reqValid = 1'b0;
  end

  // Control FSM; all outputs are registered here
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      xFirst     <= '0;
      xLast      <= '0;
      yLast      <= '0;
      pixelWrite <= 1'b0;
      pixelXAddr <= '0;
      pixelYAddr <= '0;
      pixelData  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          error <= 1'b0;
          if (start) begin
            if (reqValid) begin
              state      <= WRITE;
              xFirst     <= xStart;
              xLast      <= xLastReq;
              yLast      <= yLastReq;
              pixelXAddr <= xStart;
              pixelYAddr <= yStart;
              pixelData  <= colour;
              pixelWrite <= 1'b1;
              busy       <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Abort wins; a transfer completing on this same edge is already accepted by the driver
          if (abort) begin
            state      <= IDLE;
            pixelWrite <= 1'b0;
            busy       <= 1'b0;
          end else if (pixelReady) begin
            if (pixelXAddr == xLast && pixelYAddr == yLast) begin
              state      <= DONE;
              pixelWrite <= 1'b0;
              done       <= 1'b1;
            end else if (pixelXAddr == xLast) begin
              pixelXAddr <= xFirst;
              pixelYAddr <= pixelYAddr + Y_WIDTH'(1);
            end else begin
              pixelXAddr <= pixelXAddr + X_WIDTH'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          pixelWrite <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          error      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_rect_writer.sv
// tb/tb_pixel_rect_writer.sv - self-checking bench for pixel_rect_writer
module tb_pixel_rect_writer;

  typedef struct packed {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } pixT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  xStart = '0;
  logic [7:0]  xEnd = '0;
  logic [8:0]  yStart = '0;
  logic [8:0]  yEnd = '0;
  logic [15:0] colour = '0;
  logic        pixelReady = 1'b1;
  logic        pixelWrite;
  logic [7:0]  pixelXAddr;
  logic [8:0]  pixelYAddr;
  logic [15:0] pixelData;
  logic        busy;
  logic        done;
  logic        error;

  int  tests = 0;
  int  fails = 0;
  int  transferCount = 0;
  bit  toggleReady = 1'b0;
  pixT expQ[$];

  pixel_rect_writer dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .abort(abort),
    .xStart(xStart), .xEnd(xEnd), .yStart(yStart), .yEnd(yEnd), .colour(colour),
    .pixelReady(pixelReady), .pixelWrite(pixelWrite), .pixelXAddr(pixelXAddr),
    .pixelYAddr(pixelYAddr), .pixelData(pixelData), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: a request is legal when every corner it touches is on screen and ordered
  function automatic bit reqOk(input bit m, input int xs, input int xe, input int ys, input int ye);
    if (xs > 239 || ys > 319) return 1'b0;
    if (m && (xe > 239 || ye > 319 || xe < xs || ye < ys)) return 1'b0;
    return 1'b1;
  endfunction

  // Every presented pixel must be the head of the expected raster list
  always @(negedge clock) begin
    if (!reset && pixelWrite) begin
      if (expQ.size() == 0) begin
        check("unexpected pixelWrite", 1, 0);
      end else begin
        check("pixel x/y/data", {pixelXAddr, pixelYAddr, pixelData}, expQ[0]);
        if (pixelReady) begin
          void'(expQ.pop_front());
          transferCount++;
        end
      end
    end
  end

  always @(posedge clock) begin
    if (toggleReady) #1 pixelReady = ~pixelReady;
  end

  task automatic startOp(input bit m, input int xs, input int xe, input int ys, input int ye,
                         input logic [15:0] c);
    transferCount = 0;
    mode = m; xStart = xs[7:0]; xEnd = xe[7:0]; yStart = ys[8:0]; yEnd = ye[8:0]; colour = c;
    start = 1'b1;
    if (reqOk(m, xs, xe, ys, ye)) begin
      if (m) begin
        for (int y = ys; y <= ye; y++)
          for (int x = xs; x <= xe; x++)
            expQ.push_back({x[7:0], y[8:0], c});
      end else begin
        expQ.push_back({xs[7:0], ys[8:0], c});
      end
    end
    @(posedge clock); #1;
    start = 1'b0;
    // Scramble inputs: the DUT must have latched them
    mode = ~m; xStart = 8'hAA; xEnd = 8'h01; yStart = 9'h155; yEnd = 9'h002; colour = ~c;
  endtask

  task automatic waitDone(input string name, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
    end
    check({name, " done seen"}, done, 1);
    check({name, " busy in DONE"}, busy, 1);
    check({name, " pixelWrite off in DONE"}, pixelWrite, 0);
    check({name, " all pixels written"}, expQ.size(), 0);
    @(posedge clock); #1;
    check({name, " done one cycle"}, done, 0);
    check({name, " busy cleared"}, busy, 0);
  endtask

  initial begin
    int cyc;
    #3;
    check("reset outputs", {pixelWrite, busy, done, error, pixelXAddr, pixelYAddr, pixelData}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Single pixel; xEnd < xStart must be ignored in mode 0
    startOp(1'b0, 10, 0, 20, 0, 16'hF800);
    check("single model size", expQ.size(), 1);
    check("single model head", expQ[0], {8'd10, 9'd20, 16'hF800});
    check("single busy", busy, 1);
    waitDone("single", cyc);
    check("single latency", cyc, 1);
    check("single count", transferCount, 1);

    // Rectangle with continuous ready: no gap cycles
    startOp(1'b1, 5, 7, 3, 4, 16'h07E0);
    check("rect model size", expQ.size(), 6);
    check("rect model [2]", {expQ[2].x, expQ[2].y}, {8'd7, 9'd3});
    check("rect model [3]", {expQ[3].x, expQ[3].y}, {8'd5, 9'd4});
    waitDone("rect", cyc);
    check("rect latency", cyc, 6);
    check("rect count", transferCount, 6);

    // Same rectangle under backpressure, with a stray start while busy
    toggleReady = 1'b1;
    startOp(1'b1, 5, 7, 3, 4, 16'h001F);
    @(posedge clock); #1;
    mode = 1'b1; xStart = 8'd0; xEnd = 8'd9; yStart = 9'd0; yEnd = 9'd9;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("start while busy no error", error, 0);
    waitDone("backpressure", cyc);
    check("backpressure count", transferCount, 6);
    toggleReady = 1'b0;
    @(posedge clock); #1;
    pixelReady = 1'b1;

    // Invalid requests
    startOp(1'b1, 100, 50, 0, 0, 16'h1234);
    check("xEnd<xStart error", error, 1);
    check("xEnd<xStart idle", {busy, pixelWrite}, 0);
    @(posedge clock); #1;
    check("error one cycle", error, 0);
    startOp(1'b1, 0, 240, 0, 0, 16'h1234);
    check("xEnd=240 error", error, 1);
    check("xEnd=240 idle", {busy, pixelWrite}, 0);
    startOp(1'b0, 240, 0, 0, 0, 16'h1234);
    check("single xStart=240 error", error, 1);
    @(posedge clock); #1;
    check("error cleared", error, 0);

    // Abort in IDLE does nothing; start+abort together starts
    abort = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("idle abort no effect", {busy, done, error, pixelWrite}, 0);
    startOp(1'b0, 1, 0, 2, 0, 16'hBEEF);
    abort = 1'b0;
    check("start+abort starts", busy, 1);
    waitDone("start+abort", cyc);

    // Full-screen fill aborted after 50 transfers (the abort edge adds one more)
    startOp(1'b1, 0, 239, 0, 319, 16'hFFFF);
    cyc = 0;
    while (transferCount < 50 && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("reached 50 transfers", transferCount, 50);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort pixelWrite", pixelWrite, 0);
    check("abort count", transferCount, 51);
    check("abort remaining", expQ.size(), 76800 - 51);
    expQ.delete();
    repeat (3) begin
      @(posedge clock); #1;
      check("abort no done", done, 0);
    end

    // Full-screen fill cut by asynchronous reset mid-cycle
    startOp(1'b1, 0, 239, 0, 319, 16'h5555);
    repeat (20) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("async reset outputs", {pixelWrite, busy, done, error, pixelXAddr, pixelYAddr, pixelData}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    expQ.delete();
    startOp(1'b0, 3, 0, 4, 0, 16'hA5A5);
    check("post-reset start accepted", busy, 1);
    waitDone("post-reset", cyc);
    check("post-reset count", transferCount, 1);

    // Bottom-right corner as a one-pixel rectangle
    startOp(1'b1, 239, 239, 319, 319, 16'h0F0F);
    check("corner model head", expQ[0], {8'd239, 9'd319, 16'h0F0F});
    waitDone("corner", cyc);
    check("corner latency", cyc, 1);
    check("corner count", transferCount, 1);
    repeat (2) @(posedge clock);
    #1;
    check("corner idle", {busy, pixelWrite}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
